// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared FSM state encodings and cycle-type constants for the USB register bridge
package usb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic CYC_ADDR = 1'b0;
  localparam logic CYC_DATA = 1'b1;

endpackage

// File: rtl/usb_sync.sv
// rtl/usb_sync.sv - two-flop synchroniser for one host strobe/direction pin, idles high
module usb_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/usb_reg_bridge.sv
// rtl/usb_reg_bridge.sv - bridges an EPP-style host strobe interface onto an internal register bus
module usb_reg_bridge
  import usb_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int AUTO_INC   = 0,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  usb_write,
  input  logic                  usb_astb,
  input  logic                  usb_dstb,
  inout  wire  [7:0]            usb_db,
  output logic                  usb_wait,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [7:0]            bus_wdata,
  input  logic [7:0]            bus_rdata,
  input  logic                  bus_ack,
  output logic                  err,
  input  logic                  err_clr
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic                  write_s, astb_s, dstb_s;
  logic [1:0]            state;
  logic                  cyc_type;
  logic                  cyc_rd;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            rdata_q;
  logic [TW-1:0]         tmo_cnt;
  logic                  tmo_hit;
  logic                  db_oe;
  logic [7:0]            db_out;

  usb_sync u_sync_write (.clk(clk), .rst_n(rst_n), .d(usb_write), .q(write_s));
  usb_sync u_sync_astb  (.clk(clk), .rst_n(rst_n), .d(usb_astb),  .q(astb_s));
  usb_sync u_sync_dstb  (.clk(clk), .rst_n(rst_n), .d(usb_dstb),  .q(dstb_s));

  assign tmo_hit  = (state == ST_BUS) && !bus_ack && (tmo_cnt == TW'(TIMEOUT - 1));
  assign usb_wait = (state == ST_HOLD);

  // Read data is only meaningful from HOLD entry; in BUS the stale latch is driven harmlessly.
  assign db_oe  = ((state == ST_BUS) || (state == ST_HOLD)) && write_s && cyc_rd;
  assign db_out = (cyc_type == CYC_ADDR) ? 8'(addr_q) : rdata_q;
  assign usb_db = db_oe ? db_out : 8'hzz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cyc_type  <= CYC_ADDR;
      cyc_rd    <= 1'b0;
      addr_q    <= '0;
      rdata_q   <= 8'h00;
      tmo_cnt   <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= 8'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          tmo_cnt <= '0;
          if (!astb_s) begin
            cyc_type <= CYC_ADDR;
            cyc_rd   <= write_s;
            if (!write_s) addr_q <= usb_db[ADDR_WIDTH-1:0];
            state <= ST_HOLD;
          end else if (!dstb_s) begin
            cyc_type  <= CYC_DATA;
            cyc_rd    <= write_s;
            bus_req   <= 1'b1;
            bus_we    <= !write_s;
            bus_addr  <= addr_q;
            bus_wdata <= usb_db;
            state     <= ST_BUS;
          end
        end
        ST_BUS: begin
          if (bus_ack) begin
            rdata_q <= bus_rdata;
            bus_req <= 1'b0;
            state   <= ST_HOLD;
          end else if (tmo_hit) begin
            rdata_q <= 8'hFF;
            bus_req <= 1'b0;
            state   <= ST_HOLD;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        ST_HOLD: begin
          if (astb_s && dstb_s) begin
            if ((AUTO_INC != 0) && (cyc_type == CYC_DATA)) addr_q <= addr_q + ADDR_WIDTH'(1);
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Sticky error: a timeout in the same cycle as err_clr keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err <= 1'b0;
    else if (tmo_hit) err <= 1'b1;
    else if (err_clr) err <= 1'b0;
  end

endmodule

// File: tb/tb_usb_reg_bridge.sv
// tb/tb_usb_reg_bridge.sv - scoreboard bench for usb_reg_bridge with directed host cycles
module tb_usb_reg_bridge;

  localparam int AW = 4;

  typedef struct {
    bit         we;
    logic [3:0] addr;
    logic [7:0] wdata;
  } bus_exp_t;

  typedef struct {
    bit         rd;
    bit         lat;
    logic [7:0] data;
    bit         err;
  } host_exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          usb_write = 1'b0;
  logic          usb_astb = 1'b1;
  logic          usb_dstb = 1'b1;
  wire  [7:0]    usb_db;
  logic [7:0]    host_db = 8'h00;
  logic          host_oe = 1'b0;
  logic          usb_wait;
  logic          bus_req, bus_we;
  logic [AW-1:0] bus_addr;
  logic [7:0]    bus_wdata;
  logic [7:0]    bus_rdata = 8'h00;
  logic          bus_ack = 1'b0;
  logic          err;
  logic          err_clr = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int resp_delay = 100;
  logic [7:0] resp_data = 8'h00;
  int ack_cyc = 0;
  logic [AW-1:0] model_addr = '0;

  bus_exp_t  exp_bus[$];
  host_exp_t exp_host[$];

  assign usb_db = host_oe ? host_db : 8'hzz;

  usb_reg_bridge #(.ADDR_WIDTH(AW), .AUTO_INC(1), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .usb_write(usb_write), .usb_astb(usb_astb),
    .usb_dstb(usb_dstb), .usb_db(usb_db), .usb_wait(usb_wait), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ack(bus_ack), .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  // Bus-side responder: acks resp_delay cycles after seeing bus_req.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus_ack = 1'b0;
        cnt = 0;
      end else if (bus_ack) begin
        bus_ack = 1'b0;
        cnt = 0;
      end else if (bus_req) begin
        if (cnt == resp_delay - 1) begin
          bus_ack   = 1'b1;
          bus_rdata = resp_data;
          ack_cyc   = cyc;
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: pops an expectation at each rising bus_req and each rising usb_wait.
  initial begin
    bit pr, pw;
    bus_exp_t be;
    host_exp_t he;
    pr = 1'b0;
    pw = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pr = 1'b0;
        pw = 1'b0;
      end else begin
        if (bus_req && !pr) begin
          if (exp_bus.size() == 0) check("bus_unexpected", 1, 0);
          else begin
            be = exp_bus.pop_front();
            check("bus_we", bus_we, be.we);
            check("bus_addr", bus_addr, be.addr);
            if (be.we) check("bus_wdata", bus_wdata, be.wdata);
          end
        end
        if (usb_wait && !pw) begin
          if (exp_host.size() == 0) check("host_unexpected", 1, 0);
          else begin
            he = exp_host.pop_front();
            if (he.rd) check("host_rdata", usb_db, he.data);
            check("host_err", err, he.err);
            if (he.lat) check("wait_after_ack", cyc, ack_cyc + 1);
          end
        end
        pr = bus_req;
        pw = usb_wait;
      end
    end
  end

  task automatic wait_wait(input logic v, input string nm);
    int n;
    n = 0;
    while (usb_wait !== v && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(nm, usb_wait, v);
  endtask

  task automatic host_cycle(input bit is_addr, input bit rd, input logic [7:0] d);
    @(negedge clk);
    usb_write = rd;
    host_db   = d;
    host_oe   = !rd;
    if (is_addr) usb_astb = 1'b0;
    else         usb_dstb = 1'b0;
    wait_wait(1'b1, "wait_rise");
    usb_astb = 1'b1;
    usb_dstb = 1'b1;
    wait_wait(1'b0, "wait_fall");
    host_oe   = 1'b0;
    usb_write = 1'b0;
  endtask

  initial begin
    int n, k;
    repeat (3) @(negedge clk);
    check("rst_wait", usb_wait, 0);
    check("rst_req", bus_req, 0);
    check("rst_we", bus_we, 0);
    check("rst_addr", bus_addr, 0);
    check("rst_wdata", bus_wdata, 0);
    check("rst_err", err, 0);
    check("rst_db_oe", dut.db_oe, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    exp_host.push_back('{rd: 0, lat: 0, data: 8'h00, err: 0});
    host_cycle(1, 0, 8'h05);
    model_addr = 4'h5;
    exp_host.push_back('{rd: 1, lat: 0, data: 8'h05, err: 0});
    host_cycle(1, 1, 8'h00);
    check("idle_db_hiz", dut.db_oe, 0);

    resp_delay = 3;
    exp_bus.push_back('{we: 1, addr: model_addr, wdata: 8'h6A});
    exp_host.push_back('{rd: 0, lat: 1, data: 8'h00, err: 0});
    host_cycle(0, 0, 8'h6A);
    model_addr = model_addr + 1'b1;

    exp_host.push_back('{rd: 0, lat: 0, data: 8'h00, err: 0});
    host_cycle(1, 0, 8'h0F);
    model_addr = 4'hF;
    resp_delay = 1;
    resp_data  = 8'h11;
    exp_bus.push_back('{we: 0, addr: model_addr, wdata: 8'h00});
    exp_host.push_back('{rd: 1, lat: 1, data: 8'h11, err: 0});
    host_cycle(0, 1, 8'h00);
    model_addr = model_addr + 1'b1;
    resp_data = 8'h22;
    exp_bus.push_back('{we: 0, addr: model_addr, wdata: 8'h00});
    exp_host.push_back('{rd: 1, lat: 1, data: 8'h22, err: 0});
    host_cycle(0, 1, 8'h00);
    model_addr = model_addr + 1'b1;
    exp_host.push_back('{rd: 1, lat: 0, data: 8'h01, err: 0});
    host_cycle(1, 1, 8'h00);

    resp_delay = 100;
    exp_bus.push_back('{we: 0, addr: model_addr, wdata: 8'h00});
    exp_host.push_back('{rd: 1, lat: 0, data: 8'hFF, err: 1});
    fork
      host_cycle(0, 1, 8'h00);
      begin
        n = 0;
        k = 0;
        while (!bus_req && k < 40) begin
          @(negedge clk);
          k++;
        end
        while (bus_req && n < 40) begin
          @(negedge clk);
          n++;
        end
        check("tmo_req_cycles", n, 4);
      end
    join
    model_addr = model_addr + 1'b1;
    repeat (3) @(negedge clk);
    check("err_sticky", err, 1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("err_cleared", err, 0);

    exp_bus.push_back('{we: 1, addr: model_addr, wdata: 8'h3C});
    @(negedge clk);
    usb_write = 1'b0;
    host_db   = 8'h3C;
    host_oe   = 1'b1;
    usb_dstb  = 1'b0;
    k = 0;
    while (!bus_req && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("bus_entered", bus_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_wait", usb_wait, 0);
    check("mid_rst_req", bus_req, 0);
    check("mid_rst_db_oe", dut.db_oe, 0);
    check("mid_rst_addr", bus_addr, 0);
    usb_dstb = 1'b1;
    host_oe  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_addr = '0;
    repeat (2) @(negedge clk);
    exp_host.push_back('{rd: 1, lat: 0, data: 8'h00, err: 0});
    host_cycle(1, 1, 8'h00);

    repeat (3) @(negedge clk);
    check("bus_queue_empty", exp_bus.size(), 0);
    check("host_queue_empty", exp_host.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/usb_reg_bridge.md
USB_REG_BRIDGE -- requirements
Module: usb_reg_bridge

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, SHALL set register address width, legal range 1..8.
REQ-002 Parameter AUTO_INC, default 0, SHALL enable address post-increment after each data cycle when 1.
REQ-003 Parameter TIMEOUT, default 255, SHALL set the number of clk cycles to wait for bus_ack before abandoning a data cycle, minimum 1.
REQ-004 clk  input  1  SHALL be the single system clock; all flops use its rising edge.
REQ-005 rst_n  input  1  SHALL be the reset, asynchronous and active-low.
REQ-006 usb_write  input  1  SHALL be the host direction (0 = host writes, 1 = host reads).
REQ-007 usb_astb  input  1  SHALL be the host address strobe, active-low.
REQ-008 usb_dstb  input  1  SHALL be the host data strobe, active-low.
REQ-009 usb_db  inout  8  SHALL be the shared parallel data bus.
REQ-010 usb_wait  output  1  SHALL be the handshake to the host, high = cycle serviced.
REQ-011 bus_req, bus_we  output  1 each  SHALL be the internal register-bus request and write-enable.
REQ-012 bus_addr  output  ADDR_WIDTH  SHALL be the internal register address.
REQ-013 bus_wdata  output  8, bus_rdata  input  8, bus_ack  input  1  SHALL be the internal data and completion signals.
REQ-014 err  output  1 (sticky timeout flag); err_clr  input  1 (synchronous clear) SHALL complete the port list.

Function
REQ-015 usb_write, usb_astb, usb_dstb SHALL pass through two-flop synchronisers; all decisions use synchronised values (pin-to-state latency 2 clk).
REQ-016 FSM states SHALL be IDLE, BUS, HOLD.
REQ-017 IDLE with synced astb low SHALL start an address cycle; synced astb and dstb both low SHALL treat as address cycle (astb priority).
REQ-018 Address write: usb_db[ADDR_WIDTH-1:0] SHALL be latched into the address register on the detecting cycle, next state HOLD.
REQ-019 Address read: block SHALL drive the address zero-extended to 8 bits on usb_db, next state HOLD.
REQ-020 IDLE with synced dstb low SHALL enter BUS with bus_req=1, bus_addr=address, bus_we=!synced write, bus_wdata=usb_db sampled that cycle.
REQ-021 BUS SHALL hold bus_req and all bus outputs stable until bus_ack=1; bus_rdata is captured on the ack cycle; bus_req drops the following cycle; next state HOLD.
REQ-022 If TIMEOUT cycles elapse in BUS without bus_ack, the block SHALL drop bus_req, set err, load read data 8'hFF, and enter HOLD.
REQ-023 usb_wait SHALL be 1 exactly while in HOLD.
REQ-024 usb_db SHALL be driven only while synced write=1 during a read cycle in BUS or HOLD (read data valid from the HOLD entry), else high-Z.
REQ-025 HOLD SHALL return to IDLE on the first cycle both synced strobes are high; usb_wait drops that cycle.
REQ-026 With AUTO_INC=1, the address SHALL increment by 1 on HOLD exit of every data cycle (including timed-out ones), wrapping modulo 2^ADDR_WIDTH.
REQ-027 err_clr SHALL clear err unless a timeout sets it in the same cycle (set wins).
REQ-028 Strobes asserted while in HOLD or BUS SHALL NOT start a new cycle until IDLE is re-entered.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, usb_wait=0, usb_db high-Z, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, address=0, err=0, synchronisers to 1, timeout counter 0, including mid-cycle.

Structure
REQ-030 FSM state encodings and cycle-type constants SHALL live in shared package usb_pkg.
REQ-031 The two-flop synchroniser SHALL be sub-module usb_sync, instantiated per strobe/direction input.

Verification
REQ-032 Address write 8'h05, then address read -> usb_db=8'h05 while usb_wait=1; wait falls after astb release.
REQ-033 Data write 8'h6A to address 8'h05, ack after 3 cycles -> bus_req=1, bus_we=1, bus_addr=8'h05, bus_wdata=8'h6A; usb_wait rises the cycle after ack.
REQ-034 AUTO_INC=1, ADDR_WIDTH=4, address 4'hF, two data reads returning 8'h11, 8'h22 -> bus_addr 4'hF then 4'h0, host receives 8'h11, 8'h22.
REQ-035 TIMEOUT=4, data read with no ack -> bus_req high 4 cycles, usb_db=8'hFF, err=1 until err_clr pulse.
REQ-036 rst_n pulled low while in BUS -> usb_wait=0, bus_req=0, usb_db high-Z, address 0; next address read returns 8'h00.
